// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, counter width helper,
// and the width of the dynamic divider selects.
package pll_seq_pkg;

    localparam int SEL_W = 6;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    // One extra bit above the compare limit, so a counter can reach the limit without wrapping.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync2.sv
// Two-flop synchroniser for a single asynchronous level input; both stages reset to 0.
module sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments, so both stages sample the
    // pre-edge values and the chain really delays by two clocks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rPLL reset/lock sequencer with divider reconfiguration handshake.
// Optional status ports (lock_loss_cnt, retry_cnt) are built when PLL_SEQ_STATUS_EN is defined.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int               PLL_RST_CYC  = 16,
    parameter int               LOCK_TIMEOUT = 27000,
    parameter int               STABLE_CYC   = 1024,
    parameter int               MAX_RETRY    = 4,
    parameter logic [SEL_W-1:0] DEF_IDSEL    = 6'd0,
    parameter logic [SEL_W-1:0] DEF_FBDSEL   = 6'd0,
    parameter logic [SEL_W-1:0] DEF_ODSEL    = 6'd0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic [SEL_W-1:0] pll_idsel,
    output logic [SEL_W-1:0] pll_fbdsel,
    output logic [SEL_W-1:0] pll_odsel,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SEL_W-1:0] cfg_idsel,
    input  logic [SEL_W-1:0] cfg_fbdsel,
    input  logic [SEL_W-1:0] cfg_odsel,
    output logic             sys_resetn,
    output logic             locked,
    output logic             fail
`ifdef PLL_SEQ_STATUS_EN
    ,
    output logic [7:0]       lock_loss_cnt,
    output logic [2:0]       retry_cnt
`endif
);

    localparam int RST_W = cnt_w(PLL_RST_CYC);
    localparam int TMO_W = cnt_w(LOCK_TIMEOUT);
    localparam int STB_W = cnt_w(STABLE_CYC);
    localparam int RTY_W = cnt_w(MAX_RETRY);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYC - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

    state_t           state, state_n;
    logic [RST_W-1:0] rst_cnt, rst_cnt_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
    logic [STB_W-1:0] stab_cnt, stab_cnt_n;
    logic [RTY_W-1:0] retry_q, retry_n;
    logic             lock_s;
    logic             cfg_take;

    sync2 u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_lock),
        .q      (lock_s)
    );

    assign cfg_ready = (state == RUN) || (state == FAIL);
    assign cfg_take  = cfg_valid && cfg_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        rst_cnt_n  = rst_cnt;
        tmo_cnt_n  = tmo_cnt;
        stab_cnt_n = stab_cnt;
        retry_n    = retry_q;

        unique case (state)
            PLL_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_n   = WAIT_LOCK;
                    rst_cnt_n = '0;
                    tmo_cnt_n = '0;
                end else begin
                    rst_cnt_n = rst_cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // Timeout budget is shared across STABLE excursions, so >= rather than ==.
                tmo_cnt_n = tmo_cnt + 1'b1;
                if (lock_s) begin
                    state_n    = STABLE;
                    stab_cnt_n = '0;
                end else if (tmo_cnt >= TMO_LAST) begin
                    retry_n   = retry_q + 1'b1;
                    rst_cnt_n = '0;
                    state_n   = (retry_q == RTY_LAST) ? FAIL : PLL_RST;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                end else if (stab_cnt == STB_LAST) begin
                    state_n = RUN;
                    retry_n = '0;
                end else begin
                    stab_cnt_n = stab_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_n   = PLL_RST;
                    rst_cnt_n = '0;
                end
            end
            FAIL: begin
                state_n = FAIL;
            end
            default: begin
                state_n = PLL_RST;
            end
        endcase

        // A config accept overrides any concurrent lock loss: one PLL_RST entry only.
        if (cfg_take) begin
            state_n   = PLL_RST;
            rst_cnt_n = '0;
            retry_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= PLL_RST;
            rst_cnt    <= '0;
            tmo_cnt    <= '0;
            stab_cnt   <= '0;
            retry_q    <= '0;
            pll_reset  <= 1'b1;
            sys_resetn <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            pll_idsel  <= DEF_IDSEL;
            pll_fbdsel <= DEF_FBDSEL;
            pll_odsel  <= DEF_ODSEL;
        end else begin
            state      <= state_n;
            rst_cnt    <= rst_cnt_n;
            tmo_cnt    <= tmo_cnt_n;
            stab_cnt   <= stab_cnt_n;
            retry_q    <= retry_n;
            pll_reset  <= (state_n == PLL_RST) || (state_n == FAIL);
            fail       <= (state_n == FAIL);
            // Release one cycle after entering RUN; drop on the very edge that leaves it.
            sys_resetn <= (state == RUN) && (state_n == RUN);
            locked     <= (state == RUN) && (state_n == RUN);
            if (cfg_take) begin
                pll_idsel  <= cfg_idsel;
                pll_fbdsel <= cfg_fbdsel;
                pll_odsel  <= cfg_odsel;
            end
        end
    end

`ifdef PLL_SEQ_STATUS_EN
    logic [7:0] loss_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            loss_q <= '0;
        end else if ((state == RUN) && !lock_s && !cfg_take && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
    assign retry_cnt     = 3'(retry_q);
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: power-up vector table plus multi-cycle sequences
// for lock loss, reconfiguration, timeout/retry, flapping lock and async reset.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
    logic       sys_resetn, locked, fail;
`ifdef PLL_SEQ_STATUS_EN
    logic [7:0] lock_loss_cnt;
    logic [2:0] retry_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .PLL_RST_CYC  (4),
        .LOCK_TIMEOUT (50),
        .STABLE_CYC   (8),
        .MAX_RETRY    (3)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_idsel  (cfg_idsel),
        .cfg_fbdsel (cfg_fbdsel),
        .cfg_odsel  (cfg_odsel),
        .sys_resetn (sys_resetn),
        .locked     (locked),
        .fail       (fail)
`ifdef PLL_SEQ_STATUS_EN
        ,
        .lock_loss_cnt (lock_loss_cnt),
        .retry_cnt     (retry_cnt_o)
`endif
    );

    typedef struct {
        logic       lock;
        logic       cfg_valid;
        logic       e_pll_reset;
        logic       e_sys_resetn;
        logic       e_locked;
        logic       e_fail;
        logic       e_cfg_ready;
        logic [5:0] e_idsel;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return sys_resetn;
            default: return pll_reset;
        endcase
    endfunction

    // Number of consecutive negedge samples (starting now) where the signal equals val.
    task automatic measure(input int sel, input logic val, output int len);
        len = 0;
        while (sig(sel) === val && len < 500) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic wait_sig(input string name, input int sel, input logic val,
                            input int bound, output int cyc);
        cyc = 0;
        while (sig(sel) !== val && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 32'(sig(sel)), 32'(val));
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn    = 1'b0;
        pll_lock  = 1'b0;
        cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  len;
        int  cyc;
        bit  rose;
        bit  released;

        resetn     = 1'b1;
        pll_lock   = 1'b0;
        cfg_valid  = 1'b0;
        cfg_idsel  = 6'h2A;
        cfg_fbdsel = 6'h15;
        cfg_odsel  = 6'h0C;
        #2 resetn = 1'b0;
        #1;
        check("reset pll_reset",  32'(pll_reset),  32'd1);
        check("reset sys_resetn", 32'(sys_resetn), 32'd0);
        check("reset locked",     32'(locked),     32'd0);
        check("reset fail",       32'(fail),       32'd0);
        check("reset cfg_ready",  32'(cfg_ready),  32'd0);
        check("reset idsel",      32'(pll_idsel),  32'd0);
        check("reset fbdsel",     32'(pll_fbdsel), 32'd0);
        check("reset odsel",      32'(pll_odsel),  32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Power-up table, row k = sample after the k-th posedge following release.
        // Rows 1-3: PLL RESET held (4 cycles incl. release). Row 4: WAIT_LOCK.
        // Lock driven before posedge 5: synced after 6, STABLE at 7, RUN at 15, release at 16.
        // cfg_valid held while not ready; it must be ignored.
        for (int k = 1; k <= 17; k++) begin
            vecs[k-1].lock         = (k >= 5);
            vecs[k-1].cfg_valid    = (k <= 15);
            vecs[k-1].e_pll_reset  = (k <= 3);
            vecs[k-1].e_sys_resetn = (k >= 16);
            vecs[k-1].e_locked     = (k >= 16);
            vecs[k-1].e_fail       = 1'b0;
            vecs[k-1].e_cfg_ready  = (k >= 15);
            vecs[k-1].e_idsel      = 6'h00;
        end
        for (int i = 0; i < 17; i++) begin
            pll_lock  = vecs[i].lock;
            cfg_valid = vecs[i].cfg_valid;
            @(negedge clk);
            check($sformatf("vec%0d pll_reset", i+1),  32'(pll_reset),  32'(vecs[i].e_pll_reset));
            check($sformatf("vec%0d sys_resetn", i+1), 32'(sys_resetn), 32'(vecs[i].e_sys_resetn));
            check($sformatf("vec%0d locked", i+1),     32'(locked),     32'(vecs[i].e_locked));
            check($sformatf("vec%0d fail", i+1),       32'(fail),       32'(vecs[i].e_fail));
            check($sformatf("vec%0d cfg_ready", i+1),  32'(cfg_ready),  32'(vecs[i].e_cfg_ready));
            check($sformatf("vec%0d idsel", i+1),      32'(pll_idsel),  32'(vecs[i].e_idsel));
        end
        cfg_valid = 1'b0;

        // One-cycle lock drop in RUN.
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        wait_sig("loss sys_resetn drop", 0, 1'b0, 3, cyc);
        check("loss drop latency <= 3", 32'(cyc >= 1 && cyc <= 3), 32'd1);
        check("loss pll_reset high", 32'(pll_reset), 32'd1);
        measure(1, 1'b1, len);
        check("loss pll_reset width", 32'(len), 32'd4);
        wait_sig("loss relock", 0, 1'b1, 40, cyc);
        check("loss relock latency", 32'(cyc), 32'd10);

        // Reconfiguration accepted in RUN.
        cfg_valid  = 1'b1;
        cfg_idsel  = 6'h03;
        cfg_fbdsel = 6'h05;
        cfg_odsel  = 6'h07;
        #1;
        check("cfg ready in RUN", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("cfg idsel latched",  32'(pll_idsel),  32'h03);
        check("cfg fbdsel latched", 32'(pll_fbdsel), 32'h05);
        check("cfg odsel latched",  32'(pll_odsel),  32'h07);
        check("cfg pll_reset",      32'(pll_reset),  32'd1);
        check("cfg sys_resetn",     32'(sys_resetn), 32'd0);
        check("cfg ready dropped",  32'(cfg_ready),  32'd0);
        measure(1, 1'b1, len);
        check("cfg pll_reset width", 32'(len), 32'd4);
        wait_sig("cfg relock", 0, 1'b1, 40, cyc);
        check("cfg relock latency", 32'(cyc), 32'd10);
        check("cfg idsel kept", 32'(pll_idsel), 32'h03);

        // Lock loss and cfg accept on the same edge: one PLL_RST entry.
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        cfg_valid = 1'b1;
        cfg_odsel = 6'h11;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("simul odsel", 32'(pll_odsel), 32'h11);
        check("simul pll_reset", 32'(pll_reset), 32'd1);
        measure(1, 1'b1, len);
        check("simul pll_reset width", 32'(len), 32'd4);
        pll_lock = 1'b1;
        wait_sig("simul relock", 0, 1'b1, 40, cyc);

        // Flapping lock: never released, shared timeout eventually retries.
        do_reset();
        measure(1, 1'b1, len);
        check("flap first pulse", 32'(len), 32'd4);
        cyc = 0;
        rose = 1'b0;
        released = 1'b0;
        while (!rose && cyc < 300) begin
            pll_lock = ((cyc % 10) < 5);
            @(negedge clk);
            cyc++;
            if (sys_resetn) released = 1'b1;
            if (pll_reset) rose = 1'b1;
        end
        check("flap retry happened", 32'(rose), 32'd1);
        check("flap never released", 32'(released), 32'd0);
        check("flap timeout > 50 cyc", 32'(cyc > 50), 32'd1);

        // Lock never rises: three 4-cycle pulses, 50-cycle waits, then FAIL.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            measure(1, 1'b1, len);
            check($sformatf("nolock pulse%0d width", p), 32'(len), 32'd4);
            measure(1, 1'b0, len);
            check($sformatf("nolock wait%0d width", p), 32'(len), 32'd50);
        end
        check("fail asserted",      32'(fail),       32'd1);
        check("fail pll_reset",     32'(pll_reset),  32'd1);
        check("fail cfg_ready",     32'(cfg_ready),  32'd1);
        check("fail sys_resetn",    32'(sys_resetn), 32'd0);
        repeat (5) @(negedge clk);
        check("fail sticky", 32'(fail), 32'd1);
        pll_lock  = 1'b1;
        cfg_valid = 1'b1;
        cfg_idsel = 6'h3F;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("fail exit", 32'(fail), 32'd0);
        check("fail exit idsel", 32'(pll_idsel), 32'h3F);
        check("fail exit pll_reset", 32'(pll_reset), 32'd1);
        wait_sig("fail recover relock", 0, 1'b1, 60, cyc);

        // Async reset mid-STABLE.
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        wait_sig("stable pll_reset", 1, 1'b1, 5, cyc);
        measure(1, 1'b1, len);
        repeat (3) @(negedge clk);
        check("stable pre pll_reset", 32'(pll_reset), 32'd0);
        check("stable pre sys_resetn", 32'(sys_resetn), 32'd0);
        #2 resetn = 1'b0;
        #1;
        check("async pll_reset", 32'(pll_reset), 32'd1);
        check("async idsel",     32'(pll_idsel), 32'd0);
        check("async locked",    32'(locked),    32'd0);
        check("async cfg_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

`ifdef PLL_SEQ_STATUS_EN
        pll_lock = 1'b1;
        wait_sig("status first lock", 0, 1'b1, 40, cyc);
        check("status loss cnt 0", 32'(lock_loss_cnt), 32'd0);
        check("status retry 0", 32'(retry_cnt_o), 32'd0);
        for (int n = 0; n < 300; n++) begin
            pll_lock = 1'b0;
            @(negedge clk);
            pll_lock = 1'b1;
            wait_sig("status drop", 0, 1'b0, 5, cyc);
            wait_sig("status relock", 0, 1'b1, 40, cyc);
            if (n == 0) check("status loss cnt 1", 32'(lock_loss_cnt), 32'd1);
        end
        check("status loss cnt sat", 32'(lock_loss_cnt), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
